// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
// Shared definitions for the pipelined adder/subtractor:
//   flags_t     : flag bit order {zero, ovf, cout} used by the flags register
//                 and by the downstream flags path.
//   slice_w     : bits handled per pipeline stage (WIDTH / STAGES).
//   full_adder  : one full-adder cell, returns {carry_out, sum}.
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic cout;
    } flags_t;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Operand/result bus of the pipelined adder with valid/ready on both sides.
//   master : producer of operands and consumer of results (e.g. execute stage)
//   slave  : the adder itself
// Signals: in_valid/in_ready, a, b, cin, sub (operand side)
//          out_valid/out_ready, sum, cout, ovf, zero (result side)
// -----------------------------------------------------------------------------
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/pipelined_adder_slice.sv
// -----------------------------------------------------------------------------
// pipelined_adder_slice
// Purely combinational W-bit ripple of full-adder cells.
// Ports:
//   a, b      : W-bit slice operands (b already inverted for subtract)
//   cin       : carry into bit 0
//   s         : W-bit slice sum
//   cout      : carry out of bit W-1
//   c_msb_in  : carry into bit W-1 (overflow = c_msb_in ^ cout on the top slice)
// -----------------------------------------------------------------------------
module pipelined_adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            {c[i+1], s[i]} = full_adder(a[i], b[i], c[i]);
        end
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder/subtractor split into STAGES equal slices. Stage k adds bits
// [k*S +: S] using the carry registered by stage k-1; untouched upper operand
// bits travel forward with the op and finished lower sum bits are carried
// along, so the last stage register holds the complete result and flags.
// One op per cycle; the whole pipe holds when the result is not taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipelined_adder_if.slave (operands in, result + flags out)
// -----------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_adder_if.slave  bus
);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be divisible by STAGES, 1 <= STAGES <= WIDTH");
    end

    localparam int S    = slice_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    // Stage inputs (combinational) and stage registers.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];
    logic [WIDTH-1:0] s_next [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    flags_t           flags_q;

    logic [S-1:0]     slice_s [STAGES];
    logic             c_out   [STAGES];
    logic             c_msb   [STAGES];

    logic adv;

    // Single global advance: the pipe moves only if the output slot is free
    // or being drained, so in_ready never looks at in_valid.
    assign adv          = ~v_q[LAST] | bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 0 takes the bus; later stages take the previous stage register.
    always_comb begin
        a_in[0] = bus.a;
        b_in[0] = bus.sub ? ~bus.b : bus.b;
        c_in[0] = bus.cin;
        s_in[0] = '0;
        v_in[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_slice #(.W(S)) u_slice (
            .a        (a_in[k][k*S +: S]),
            .b        (b_in[k][k*S +: S]),
            .cin      (c_in[k]),
            .s        (slice_s[k]),
            .cout     (c_out[k]),
            .c_msb_in (c_msb[k])
        );
    end

    // Merge this stage's slice into the partial sum carried from below.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next[k]             = s_in[k];
            s_next[k][k*S +: S]   = slice_s[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbour, giving a true shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= v_in[k];
        end
    end

    // NOTE: data registers are deliberately not reset; only the valid bits
    // are, and the outputs are gated by out_valid, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_next[k];
                c_q[k] <= c_out[k];
            end
            // Overflow: carry into the MSB differs from carry out of it.
            flags_q <= '{zero: ~|s_next[LAST],
                         ovf:  c_out[LAST] ^ c_msb[LAST],
                         cout: c_out[LAST]};
        end
    end

    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = v_q[LAST] ? s_q[LAST] : '0;
    assign bus.cout      = v_q[LAST] & flags_q.cout;
    assign bus.ovf       = v_q[LAST] & flags_q.ovf;
    assign bus.zero      = v_q[LAST] & flags_q.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Four adder instances (16/4, 16/1, 16/16, 8/2) behind a selector; one linear
// stimulus sequence drives the selected instance and checks it against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    logic clk;
    logic rst_n;
    int   sel;

    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic        obs_in_ready;
    logic        obs_valid;
    logic [18:0] obs_word;   // {sum[15:0], cout, ovf, zero}

    int checks = 0;
    int errors = 0;

    // Operation lists for a stream; kexp holds constant expectations when used.
    logic [15:0] op_a[$];
    logic [15:0] op_b[$];
    logic        op_cin[$];
    logic        op_sub[$];
    logic [18:0] kexp[$];

    pipelined_adder_if #(.WIDTH(16)) if0 ();
    pipelined_adder_if #(.WIDTH(16)) if1 ();
    pipelined_adder_if #(.WIDTH(16)) if2 ();
    pipelined_adder_if #(.WIDTH(8))  if3 ();

    pipelined_adder #(.WIDTH(16), .STAGES(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pipelined_adder #(.WIDTH(16), .STAGES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pipelined_adder #(.WIDTH(16), .STAGES(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    pipelined_adder #(.WIDTH(8),  .STAGES(2))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if0.in_valid = (sel == 0) && in_valid;
    assign if1.in_valid = (sel == 1) && in_valid;
    assign if2.in_valid = (sel == 2) && in_valid;
    assign if3.in_valid = (sel == 3) && in_valid;
    assign if0.out_ready = (sel == 0) ? out_ready : 1'b1;
    assign if1.out_ready = (sel == 1) ? out_ready : 1'b1;
    assign if2.out_ready = (sel == 2) ? out_ready : 1'b1;
    assign if3.out_ready = (sel == 3) ? out_ready : 1'b1;
    assign if0.a = a;      assign if0.b = b;      assign if0.cin = cin; assign if0.sub = sub;
    assign if1.a = a;      assign if1.b = b;      assign if1.cin = cin; assign if1.sub = sub;
    assign if2.a = a;      assign if2.b = b;      assign if2.cin = cin; assign if2.sub = sub;
    assign if3.a = a[7:0]; assign if3.b = b[7:0]; assign if3.cin = cin; assign if3.sub = sub;

    always_comb begin
        obs_in_ready = 1'b0;
        obs_valid    = 1'b0;
        obs_word     = '0;
        case (sel)
            0: begin obs_in_ready = if0.in_ready; obs_valid = if0.out_valid;
                     obs_word = {if0.sum, if0.cout, if0.ovf, if0.zero}; end
            1: begin obs_in_ready = if1.in_ready; obs_valid = if1.out_valid;
                     obs_word = {if1.sum, if1.cout, if1.ovf, if1.zero}; end
            2: begin obs_in_ready = if2.in_ready; obs_valid = if2.out_valid;
                     obs_word = {if2.sum, if2.cout, if2.ovf, if2.zero}; end
            3: begin obs_in_ready = if3.in_ready; obs_valid = if3.out_valid;
                     obs_word = {8'h00, if3.sum, if3.cout, if3.ovf, if3.zero}; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain modular arithmetic on w-bit values.
    function automatic logic [18:0] ref_op(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                           input logic rcin, input logic rsub);
        longint unsigned mask, av, bv, eb, tot, s;
        logic co, sa, sb, ss, ov;
        mask = (64'd1 << w) - 1;
        av   = longint'(ra) & mask;
        bv   = longint'(rb) & mask;
        eb   = rsub ? (~bv & mask) : bv;
        tot  = av + eb + longint'(rcin);
        s    = tot & mask;
        co   = ((tot >> w) & 1) != 0;
        sa   = ((av >> (w - 1)) & 1) != 0;
        sb   = ((eb >> (w - 1)) & 1) != 0;
        ss   = ((s  >> (w - 1)) & 1) != 0;
        ov   = (sa == sb) && (ss != sa);
        return {s[15:0], co, ov, s == 0};
    endfunction

    task automatic clear_ops();
        op_a.delete(); op_b.delete(); op_cin.delete(); op_sub.delete(); kexp.delete();
    endtask

    task automatic add_random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            op_a.push_back(16'($urandom));
            op_b.push_back(16'($urandom));
            op_cin.push_back(1'($urandom));
            op_sub.push_back(1'($urandom));
        end
    endtask

    // Back-to-back stream into the selected instance. Called and returns at
    // posedge+1. out_ready is dropped for stall_len cycles from stall_start.
    task automatic run_stream(input string tag, input int stages, input int w,
                              input int stall_start, input int stall_len);
        int n, issued, done, cyc, first_acc, limit;
        logic stall;
        logic [18:0] held;
        logic [18:0] exp_q[$];
        n = op_a.size();
        issued = 0; done = 0; cyc = 0; first_acc = 0; held = '0;
        limit = n + stages + stall_len + 20;
        while (done < n && cyc < limit) begin
            stall     = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            out_ready = !stall;
            in_valid  = issued < n;
            if (stall) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end else if (issued < n) begin
                a = op_a[issued]; b = op_b[issued]; cin = op_cin[issued]; sub = op_sub[issued];
            end
            @(negedge clk);
            check({tag, "_in_ready"}, 32'(obs_in_ready), 32'(!stall));
            if (stall) begin
                if (cyc == stall_start) held = obs_word;
                else check({tag, "_held"}, 32'(obs_word), 32'(held));
                check({tag, "_held_valid"}, 32'(obs_valid), 32'd1);
            end
            if (done > 0) check({tag, "_no_gap"}, 32'(obs_valid), 32'd1);
            if (in_valid && obs_in_ready) begin
                if (kexp.size() > issued) exp_q.push_back(kexp[issued]);
                else exp_q.push_back(ref_op(w, op_a[issued], op_b[issued], op_cin[issued], op_sub[issued]));
                if (issued == 0) first_acc = cyc;
                issued++;
            end
            if (obs_valid && out_ready) begin
                if (done == 0) check({tag, "_latency"}, 32'(cyc - first_acc), 32'(stages));
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious"}, 32'(done), 32'(issued));
                end else begin
                    check({tag, "_result"}, 32'(obs_word), 32'(exp_q.pop_front()));
                end
                done++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_completed"}, 32'(done), 32'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int ghost;
        sel = 0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state of every instance.
        #12;
        check("rst_valid0", 32'(if0.out_valid), 32'd0);
        check("rst_sum0",   32'(if0.sum),       32'd0);
        check("rst_flags0", 32'({if0.cout, if0.ovf, if0.zero}), 32'd0);
        check("rst_ready0", 32'(if0.in_ready),  32'd1);
        check("rst_valid1", 32'(if1.out_valid), 32'd0);
        check("rst_valid2", 32'(if2.out_valid), 32'd0);
        check("rst_valid3", 32'(if3.out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream: four ops in, first one held at the output.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("midrst_pre_valid", 32'(obs_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(obs_valid), 32'd0);
        check("midrst_sum",   32'(obs_word),  32'd0);
        check("midrst_ready", 32'(obs_in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        ghost = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (obs_valid) ghost++;
        end
        check("midrst_no_ghost", 32'(ghost), 32'd0);
        check("midrst_ready_after", 32'(obs_in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed corner vectors with fixed expected results.
        clear_ops();
        op_a.push_back(16'h7FFF); op_b.push_back(16'h0001); op_cin.push_back(1'b0); op_sub.push_back(1'b0);
        kexp.push_back({16'h8000, 1'b0, 1'b1, 1'b0});
        op_a.push_back(16'hFFFF); op_b.push_back(16'h0001); op_cin.push_back(1'b0); op_sub.push_back(1'b0);
        kexp.push_back({16'h0000, 1'b1, 1'b0, 1'b1});
        op_a.push_back(16'h0005); op_b.push_back(16'h0007); op_cin.push_back(1'b1); op_sub.push_back(1'b1);
        kexp.push_back({16'hFFFE, 1'b0, 1'b0, 1'b0});
        op_a.push_back(16'h8000); op_b.push_back(16'h0001); op_cin.push_back(1'b1); op_sub.push_back(1'b1);
        kexp.push_back({16'h7FFF, 1'b1, 1'b1, 1'b0});
        op_a.push_back(16'h0005); op_b.push_back(16'h0007); op_cin.push_back(1'b0); op_sub.push_back(1'b1);
        kexp.push_back({16'hFFFD, 1'b0, 1'b0, 1'b0});
        run_stream("directed", 4, 16, 1000, 0);

        // Random stream with a three-cycle output stall mid-stream.
        clear_ops(); add_random_ops(8);
        run_stream("rand_s4_stall", 4, 16, 6, 3);

        sel = 1; clear_ops(); add_random_ops(8);
        run_stream("rand_s1", 1, 16, 1000, 0);

        sel = 2; clear_ops(); add_random_ops(8);
        run_stream("rand_s16", 16, 16, 1000, 0);

        // Exhaustive 8-bit operand sweep, random cin/sub per pair.
        sel = 3; clear_ops();
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                op_a.push_back(16'(i));
                op_b.push_back(16'(j));
                op_cin.push_back(1'($urandom));
                op_sub.push_back(1'($urandom));
            end
        end
        run_stream("sweep_w8", 2, 8, 1 << 20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor. It is the multi-bit successor to the single-bit full adder cell.
- The operand is split into STAGES equal slices. Each slice is a ripple of full-adder cells, and the carry is registered between slices.
- A valid/ready handshake is on both sides, so the block sits between execute-stage operand latches and the writeback/flags path.
- Throughput is one operation per cycle with no stall.

Parameters:
- WIDTH, 16, operand and result width in bits.
- STAGES, 4, number of pipeline stages (slices). Legal range is 1..WIDTH. WIDTH must be divisible by STAGES (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block accepts operand this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- sub  input  1  1 selects subtract mode
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n, with one-stage assertion.
- While rst_n = 0: all stage valid bits are 0, out_valid = 0, and sum/cout/ovf/zero = 0. in_ready = 1 after reset.
- Data registers need not be reset, but outputs must read 0 while out_valid = 0 after reset.
- Arithmetic:
  - effective B = sub ? ~b : b.
  - result = a + effB + cin, computed mod 2^WIDTH.
  - Subtract a - b requires sub=1 and cin=1. sub=1 with cin=0 gives a - b - 1 (borrow chain).
  - cout is the raw carry out of bit WIDTH-1.
  - ovf = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
  - zero = ~|sum.
- Pipeline:
  - Stage k (0-based) adds slice k, i.e. bits [k*S +: S] with S = WIDTH/STAGES, using the carry registered by stage k-1. Stage 0 uses cin.
  - Upper operand slices are carried forward unchanged (skew registers). Completed lower sum slices are carried forward (deskew).
  - ovf uses a[MSB]/effB[MSB] delayed alongside the data.
  - Latency: an operand accepted at edge t produces out_valid = 1 after edge t+STAGES-1, i.e. STAGES cycles from the in_valid&in_ready cycle to the first out_valid cycle.
  - sum/cout/ovf/zero are registered and stable while out_valid=1 && out_ready=0.
- Handshake:
  - Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_valid and out_ready only, and never dependent on in_valid.
  - Transfer in on in_valid & in_ready. Transfer out on out_valid & out_ready.
  - When adv = 0, every stage register, including valid bits, holds.
  - When adv = 1, every stage shifts by one. A bubble (valid=0) enters when in_valid=0.
  - No bubble collapse: internal bubbles propagate as empty slots.
- Boundary conditions:
  - Simultaneous accept and emit in the same cycle is legal, giving full throughput.
  - Operands and sub/cin are sampled only on the accept edge. Changes while in_ready=0 are ignored.
  - Order is preserved. No op is dropped or duplicated.
  - rst_n asserted mid-stream discards all in-flight ops immediately (asynchronously). out_valid falls without waiting for clk.
  - STAGES=1: purely registered single-cycle adder, latency 1.
  - STAGES=WIDTH: one full-adder cell per stage.

Decomposition:
- Shared header adder_defs.vh: macro/localparam SLICE_W = WIDTH/STAGES, the divisibility check, and the flag bit order {zero, ovf, cout} used by the flags register downstream.
- Sub-module adder_slice, parameter W: purely combinational ripple of W full_adder instances.
  - Ports: a[W], b[W], cin → s[W], cout, and c_msb_in (the carry into the MSB) for overflow. ovf may alternatively be computed from the sign bits as specified.
  - pipelined_adder instantiates STAGES adder_slice copies in a generate loop, plus the stage, skew and valid registers.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- Reset mid-stream: 3 ops in flight, drop rst_n between edges → out_valid=0 and sum=0 immediately. After release, in_ready=1 and none of the old ops emerge.
- a=0x7FFF, b=0x0001, cin=0, sub=0 → 4 cycles later sum=0x8000, cout=0, ovf=1, zero=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0, zero=1. Checks the carry through all three inter-stage registers.
- a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1, cin=1 → sum=0x7FFF, cout=1, ovf=1.
- Stream 8 random ops back-to-back, holding out_ready=0 for 3 cycles mid-stream → in_ready=0 exactly those cycles, held outputs stable, all 8 results in order matching the reference model, and no gaps once out_ready=1.
- Re-run the random stream at STAGES=1 (latency 1) and STAGES=16 (latency 16) → results match the model. Exhaustive 8-bit sweep at WIDTH=8, STAGES=2 against the model.
